// File: rtl/apb_wait_regs_pkg.sv
// Shared types and constants for the wait-state APB register file.
// Holds the FSM state enum, strobe/data widths and the word-index width helper.
package apb_wait_regs_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = 4;
  localparam int unsigned CntWidth  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Word-index width; a single register still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_regs_dec.sv
// Combinational APB address decode: register index, in-range flag and
// read-only flag for the register file.
module apb_wait_regs_dec
  import apb_wait_regs_pkg::*;
#(
  parameter int unsigned        NoRegs       = 8,
  parameter int unsigned        AddrWidth    = 15,
  parameter int unsigned        BaseAddr     = 0,
  parameter logic [NoRegs-1:0]  ReadOnlyMask = '0
) (
  input  logic [AddrWidth-1:0]            paddr,
  output logic [idx_width(NoRegs)-1:0]    idx,
  output logic                            valid,
  output logic                            read_only
);

  localparam int unsigned IdxWidth = idx_width(NoRegs);

  logic [AddrWidth-1:0] offset;
  logic [AddrWidth-3:0] word;

  // Wrapping subtraction pushes addresses below BaseAddr far out of range.
  assign offset = paddr - AddrWidth'(BaseAddr);
  assign word   = offset[AddrWidth-1:2];

  assign valid     = (offset[1:0] == 2'b00) && (32'(word) < NoRegs);
  assign idx       = word[IdxWidth-1:0];
  assign read_only = valid && ReadOnlyMask[idx];

endmodule

// File: rtl/apb_wait_regs.sv
// APB leaf register file with RW/RO registers and a programmable number of
// wait states before pready, used to exercise backpressure upstream.
module apb_wait_regs
  import apb_wait_regs_pkg::*;
#(
  parameter int unsigned        NoRegs       = 8,
  parameter int unsigned        AddrWidth    = 15,
  parameter int unsigned        BaseAddr     = 0,
  parameter int unsigned        WaitCycles   = 2,
  parameter logic [NoRegs-1:0]  ReadOnlyMask = '0,
  parameter logic [31:0]        ResetValue   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [AddrWidth-1:0]     paddr_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [DataWidth-1:0]     pwdata_i,
  input  logic [StrbWidth-1:0]     pstrb_i,
  output logic                     pready_o,
  output logic [DataWidth-1:0]     prdata_o,
  output logic                     pslverr_o,
  input  logic [NoRegs*32-1:0]     reg_ro_i,
  output logic [NoRegs*32-1:0]     reg_q_o
);

  localparam int unsigned IdxWidth = idx_width(NoRegs);

  state_e                state_reg, state_next;
  logic [CntWidth-1:0]   cnt_reg, cnt_next;

  logic [IdxWidth-1:0]   idx;
  logic                  valid;
  logic                  read_only;
  logic                  xfer_done;
  logic                  wr_en;
  logic [DataWidth-1:0]  reg_view [NoRegs];

  apb_wait_regs_dec #(
    .NoRegs       (NoRegs),
    .AddrWidth    (AddrWidth),
    .BaseAddr     (BaseAddr),
    .ReadOnlyMask (ReadOnlyMask)
  ) u_dec (
    .paddr     (paddr_i),
    .idx       (idx),
    .valid     (valid),
    .read_only (read_only)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        // Only a genuine SETUP phase starts a transfer; stray penable is ignored.
        if (psel_i && !penable_i) begin
          state_next = ACCESS;
          cnt_next   = CntWidth'(WaitCycles);
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The access takes effect in the single cycle pready is high.
  assign xfer_done = (state_reg == ACCESS) && psel_i && (cnt_reg == '0);
  assign wr_en     = xfer_done && pwrite_i && valid && !read_only;

  for (genvar gi = 0; gi < NoRegs; gi++) begin : g_reg
    if (ReadOnlyMask[gi]) begin : g_ro
      assign reg_view[gi] = reg_ro_i[gi*32 +: 32];
    end else begin : g_rw
      logic [DataWidth-1:0] data_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_reg <= ResetValue;
        end else if (wr_en && (idx == IdxWidth'(gi))) begin
          for (int b = 0; b < StrbWidth; b++) begin
            if (pstrb_i[b]) begin
              data_reg[b*8 +: 8] <= pwdata_i[b*8 +: 8];
            end
          end
        end
      end

      assign reg_view[gi] = data_reg;
    end
    assign reg_q_o[gi*32 +: 32] = reg_view[gi];
  end

  // Hardware values feeding RW slots are intentionally ignored.
  logic ro_unused;
  assign ro_unused = ^reg_ro_i;

  assign pready_o  = xfer_done;
  assign prdata_o  = (xfer_done && !pwrite_i && valid) ? reg_view[idx] : '0;
  assign pslverr_o = xfer_done && (!valid || (pwrite_i && read_only));

endmodule

// File: tb/tb_apb_wait_regs.sv
// Directed bench for apb_wait_regs with a register-array model checked every cycle.
module tb_apb_wait_regs;

  localparam int          NREGS   = 8;
  localparam int          AW      = 15;
  localparam int          WAIT    = 2;
  localparam logic [7:0]  RO_MASK = 8'h80;
  localparam logic [31:0] RST_VAL = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     paddr = '0;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [31:0]       pwdata = '0;
  logic [3:0]        pstrb = '0;
  logic              pready_o;
  logic [31:0]       prdata_o;
  logic              pslverr_o;
  logic [NREGS*32-1:0] reg_ro;
  logic [NREGS*32-1:0] reg_q;

  logic [31:0] model   [NREGS];
  logic [31:0] ro_vals [NREGS];

  int          n_err = 0;
  int          n_chk = 0;
  int          cyc = 0;
  bit          cmp_en = 1'b0;
  bit          exp_pready = 1'b0;
  logic [31:0] exp_rdata = '0;
  bit          exp_err = 1'b0;
  int          setup_cyc;
  int          pready_cyc;
  logic [31:0] rd_data;
  logic        rd_err;

  apb_wait_regs #(
    .NoRegs       (NREGS),
    .AddrWidth    (AW),
    .BaseAddr     (0),
    .WaitCycles   (WAIT),
    .ReadOnlyMask (RO_MASK),
    .ResetValue   (RST_VAL)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .paddr_i   (paddr),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .pstrb_i   (pstrb),
    .pready_o  (pready_o),
    .prdata_o  (prdata_o),
    .pslverr_o (pslverr_o),
    .reg_ro_i  (reg_ro),
    .reg_q_o   (reg_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    reg_ro = '0;
    for (int i = 0; i < NREGS; i++) reg_ro[i*32 +: 32] = ro_vals[i];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---- model: plain decode rules over a word array ----
  function automatic bit m_in_range(input logic [AW-1:0] a);
    return (a % 4 == 0) && (a / 4 < NREGS);
  endfunction

  function automatic bit m_is_ro(input logic [AW-1:0] a);
    return m_in_range(a) && RO_MASK[a / 4];
  endfunction

  function automatic logic [31:0] m_view(input int i);
    return RO_MASK[i] ? ro_vals[i] : model[i];
  endfunction

  function automatic bit m_err(input bit wr, input logic [AW-1:0] a);
    return !m_in_range(a) || (wr && m_is_ro(a));
  endfunction

  function automatic logic [31:0] m_rdata(input bit wr, input logic [AW-1:0] a);
    return (wr || !m_in_range(a)) ? 32'h0 : m_view(a / 4);
  endfunction

  task automatic m_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m_in_range(a) && !m_is_ro(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) model[i] = RST_VAL;
  endtask

  // ---- every-cycle compare ----
  always @(negedge clk) begin
    if (pready_o) pready_cyc = cyc;
    if (cmp_en) begin
      chk("pready", {31'b0, pready_o}, {31'b0, exp_pready});
      chk("prdata", prdata_o, exp_pready ? exp_rdata : 32'h0);
      chk("pslverr", {31'b0, pslverr_o}, {31'b0, exp_pready ? exp_err : 1'b0});
      for (int i = 0; i < NREGS; i++)
        chk($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], m_view(i));
    end
  end

  // abort_at: ACCESS cycle index at which psel is dropped, -1 for none.
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int abort_at);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    setup_cyc = cyc; pready_cyc = -1;
    rd_data = 'x; rd_err = 1'bx;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k <= WAIT; k++) begin
      if (k == abort_at) begin
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        $display("xfer %s addr=%h data=%h strb=%h aborted at access cycle %0d",
                 wr ? "WR" : "RD", a, d, s, k);
        return;
      end
      if (k == WAIT) begin
        exp_rdata  = m_rdata(wr, a);
        exp_err    = m_err(wr, a);
        exp_pready = 1'b1;
        @(negedge clk);
        rd_data = prdata_o; rd_err = pslverr_o;
        @(posedge clk);
        if (wr) m_write(a, d, s);
        #1;
        psel = 1'b0; penable = 1'b0;
        exp_pready = 1'b0; exp_rdata = '0; exp_err = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    $display("xfer %s addr=%h data=%h strb=%h -> rdata=%h err=%0b latency=%0d",
             wr ? "WR" : "RD", a, d, s, rd_data, rd_err, pready_cyc - setup_cyc);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) ro_vals[i] = 32'h0BAD0000 + i;
    ro_vals[7] = 32'hCAFEF00D;
    m_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pready", {31'b0, pready_o}, 32'h0);
    chk("reset_prdata", prdata_o, 32'h0);
    chk("reset_reg1", reg_q[63:32], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // full write with latency pinned at WaitCycles+1
    xfer(1'b1, 15'h4, 32'hDEADBEEF, 4'hF, -1);
    chk("wr_latency", 32'(pready_cyc - setup_cyc), 32'd3);
    chk("wr_err", {31'b0, rd_err}, 32'h0);
    chk("wr_reg1_next", reg_q[63:32], 32'hDEADBEEF);

    // partial strobe merge
    xfer(1'b1, 15'h4, 32'h11223344, 4'h5, -1);
    xfer(1'b0, 15'h4, 32'h0, 4'h0, -1);
    chk("strb_read", rd_data, 32'hDE22BE44);

    // read-only slot
    xfer(1'b0, 15'h1C, 32'h0, 4'h0, -1);
    chk("ro_read", rd_data, 32'hCAFEF00D);
    chk("ro_read_err", {31'b0, rd_err}, 32'h0);
    xfer(1'b1, 15'h1C, 32'h0, 4'hF, -1);
    chk("ro_write_err", {31'b0, rd_err}, 32'h1);
    xfer(1'b0, 15'h1C, 32'h0, 4'h0, -1);
    chk("ro_reread", rd_data, 32'hCAFEF00D);

    // out of range and misaligned
    xfer(1'b0, 15'h20, 32'h0, 4'h0, -1);
    chk("oor_read", rd_data, 32'h0);
    chk("oor_read_err", {31'b0, rd_err}, 32'h1);
    xfer(1'b1, 15'h6, 32'hFFFFFFFF, 4'hF, -1);
    chk("misalign_err", {31'b0, rd_err}, 32'h1);
    xfer(1'b0, 15'h4, 32'h0, 4'h0, -1);
    chk("misalign_reg1", rd_data, 32'hDE22BE44);

    // zero strobe is a legal no-op
    xfer(1'b1, 15'h8, 32'hFFFFFFFF, 4'h0, -1);
    chk("nostrb_err", {31'b0, rd_err}, 32'h0);
    xfer(1'b0, 15'h8, 32'h0, 4'h0, -1);
    chk("nostrb_read", rd_data, 32'h0);

    // abort in the second ACCESS cycle
    xfer(1'b1, 15'h8, 32'hA5A5A5A5, 4'hF, 1);
    xfer(1'b0, 15'h8, 32'h0, 4'h0, -1);
    chk("abort_read", rd_data, 32'h0);

    // penable without a SETUP phase gets no response
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 15'h4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("nosetup_pready", {31'b0, pready_o}, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    $display("xfer RD addr=0004 with penable but no SETUP -> ignored");

    // reset asserted mid-ACCESS
    xfer(1'b1, 15'hC, 32'h12345678, 4'hF, -1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 15'h10;
    pwdata = 32'h87654321; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_reset();
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg3", reg_q[127:96], RST_VAL);
    chk("rst_reg4", reg_q[159:128], RST_VAL);
    rst_n = 1'b1;
    $display("xfer WR addr=0010 data=87654321 dropped by reset mid-ACCESS");
    xfer(1'b0, 15'h4, 32'h0, 4'h0, -1);
    chk("rst_reg1_read", rd_data, RST_VAL);

    // random directed mix, all checked by the model
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 5) ro_vals[7] = $urandom;
      xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 40)), $urandom,
           4'($urandom_range(0, 15)), -1);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_wait_regs.md
Name: apb_wait_regs

Overview:
- APB slave register file at a leaf of the APB tree, directly downstream of one apb_demux master port.
- Holds NoRegs 32-bit registers, each either read/write or read-only; read-only values come from hardware inputs.
- Inserts a configurable number of wait states per transfer, so apb_demux benches can test pready backpressure.
- Signals pslverr on out-of-range or illegal accesses.

Parameters:
- NoRegs, 8, number of 32-bit registers (1..64).
- AddrWidth, 15, paddr width; matches the APB tree.
- BaseAddr, 0, byte address of register 0; word aligned.
- WaitCycles, 2, wait states inserted in ACCESS before pready (0..15).
- ReadOnlyMask, '0, NoRegs-bit mask; bit i set means register i is read-only.
- ResetValue, '0, 32-bit reset value applied to every RW register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- paddr_i  in  AddrWidth  APB address
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  1 = write
- pwdata_i  in  32  write data
- pstrb_i  in  4  byte strobes
- pready_o  out  1  transfer complete
- prdata_o  out  32  read data
- pslverr_o  out  1  slave error
- reg_ro_i  in  NoRegs*32  live values for read-only registers
- reg_q_o  out  NoRegs*32  current register contents (RO slots mirror reg_ro_i)

Behaviour:
- Reset (async, rst_ni low):
  - FSM to IDLE, wait counter to 0.
  - RW registers to ResetValue.
  - pready_o, pslverr_o and prdata_o low/zero.
- FSM states:
  - IDLE: psel_i=1 and penable_i=0 (SETUP phase) → ACCESS, load counter with WaitCycles. Anything else stays in IDLE with pready_o=0.
  - ACCESS: if psel_i drops, abort → IDLE with no register side effect. If counter != 0, decrement with pready_o=0. If counter == 0, assert pready_o for exactly one cycle, perform the access in that cycle, then → IDLE.
- Back-to-back transfers: a new SETUP is accepted only from IDLE, so the minimum transfer is 2 cycles (SETUP plus one ACCESS cycle when WaitCycles=0).
- Decode: offset = paddr_i - BaseAddr.
  - idx = offset[AddrWidth-1:2].
  - Valid when offset[1:0]==0 and idx < NoRegs; otherwise out of range.
  - Subtraction wraps modulo 2^AddrWidth, so addresses below BaseAddr decode as out of range.
- Write, valid RW register: register i byte b updates only where pstrb_i[b]=1. pstrb_i=0 is a legal no-op with pslverr_o=0.
- Write, RO register: no update, pslverr_o=1.
- Read, valid: prdata_o = register value, or reg_ro_i slice for RO registers, sampled in the pready cycle.
- Read, out of range: prdata_o=0, pslverr_o=1.
- Write, out of range: no update, pslverr_o=1.
- prdata_o and pslverr_o are valid only while pready_o=1 and are driven 0 otherwise.
- paddr_i, pwrite_i, pwdata_i and pstrb_i must stay stable during ACCESS. The block samples them in the pready cycle and does not check stability.
- penable_i=1 while in IDLE (no preceding SETUP) is ignored: no response.
- reg_q_o reflects a write from the cycle after the pready cycle.
- Reset asserted mid-ACCESS: transfer dropped, no partial write.

Decomposition:
- Shared package apb_wait_regs_pkg:
  - state enum (IDLE, ACCESS).
  - word-index width constant $clog2(NoRegs).
  - localparam for byte-strobe width (4).
- Sub-module apb_wait_regs_dec: combinational address decode producing idx, valid and read_only. It is the only natural split; the FSM, counter and storage stay in the top.

Test Plan:
- Reset release with WaitCycles=2: write 0xDEADBEEF to reg 1 (paddr 0x4, pstrb 0xF) → pready_o high exactly 3 cycles after SETUP; pslverr_o=0; reg_q_o[1]=0xDEADBEEF the next cycle.
- Partial strobe: reg 1 holds 0xDEADBEEF, write 0x11223344 with pstrb 0x5 → read back returns 0xDE22BE44.
- Read-only: ReadOnlyMask=0x80, reg_ro_i[7]=0xCAFEF00D.
  - Read paddr 0x1C → prdata_o=0xCAFEF00D, pslverr_o=0.
  - Write 0x0 to paddr 0x1C → pslverr_o=1; subsequent read still returns 0xCAFEF00D.
- Out of range and misaligned:
  - Read paddr 0x20 (NoRegs=8) → prdata_o=0, pslverr_o=1.
  - Write paddr 0x6 → pslverr_o=1; reg 1 unchanged.
- Abort and reset:
  - Drop psel_i in the second ACCESS cycle of a write → no update, FSM back in IDLE.
  - Assert rst_ni low mid-ACCESS → all RW registers return to ResetValue; pready_o never pulses.
- Integration with apb_demux (5 ports, one instance per port, WaitCycles randomised 0..5): 1000 random master transactions → every read matches a shadow model, every pslverr_o matches the decode rules, no lost requests.
